// File: rtl/chk_ctrl_pkg.sv
// chk_ctrl_pkg: shared state encoding and timestamp width for the check controller
package chk_ctrl_pkg;
  localparam int TS_W = 16;
  typedef enum logic [1:0] {SETTLE = 2'd0, ARMED = 2'd1, OFF = 2'd2} state_t;
endpackage

// File: rtl/rr_arb.sv
// rr_arb: round-robin index arbiter, search starts one past the last granted index
module rr_arb #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [$clog2(N)-1:0] grant,
  output logic                 grant_vld
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] last;
  logic [IW-1:0] idx;
  // descending loop so the closest index after last wins
  always_comb begin
    grant = '0;
    grant_vld = 1'b0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(last) + 1 + k) % N);
      if (req[idx]) begin
        grant = idx;
        grant_vld = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= IW'(N - 1);
    else if (advance && grant_vld) last <= grant;
endmodule

// File: rtl/chk_ctrl.sv
// chk_ctrl: global checker enable FSM with failure counting, overflow flags and a
// registered round-robin failure report stage
module chk_ctrl
  import chk_ctrl_pkg::*;
#(
  parameter int N_CHK      = 4,
  parameter int SETTLE_CYC = 16,
  parameter int CNT_W      = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sw_off,
  input  logic                     sw_on,
  input  logic                     sw_clr,
  input  logic [N_CHK-1:0]         chk_fail,
  output logic [N_CHK-1:0]         chk_en,
  output logic                     rpt_valid,
  input  logic                     rpt_ready,
  output logic [$clog2(N_CHK)-1:0] rpt_id,
  output logic [TS_W-1:0]          rpt_time,
  output logic [CNT_W-1:0]         fail_cnt,
  output logic [N_CHK-1:0]         ovf,
  output logic [1:0]               state
);
  localparam int IW  = $clog2(N_CHK);
  localparam int SCW = $clog2(SETTLE_CYC + 1);
  localparam int SW  = CNT_W + 5;
  state_t cur, nxt;
  logic [SCW-1:0] settle_cnt;
  logic [TS_W-1:0] cyc;
  logic [TS_W-1:0] ts [N_CHK];
  logic [N_CHK-1:0] pending, acc, stage, clr, req;
  logic load, gnt_vld;
  logic [IW-1:0] gnt;
  logic [SW-1:0] n_acc, sum;
  assign state = cur;
  assign acc   = chk_fail & chk_en;
  assign load  = !rpt_valid || rpt_ready;
  assign stage = rpt_valid ? (N_CHK'(1) << rpt_id) : '0;
  assign clr   = rpt_ready ? stage : '0;
  assign req   = pending & ~stage;
  always_comb begin
    nxt = OFF;
    case (cur)
      SETTLE:  nxt = sw_off ? OFF : (settle_cnt == SCW'(SETTLE_CYC - 1)) ? ARMED : SETTLE;
      ARMED:   nxt = sw_off ? OFF : ARMED;
      OFF:     nxt = (sw_on && !sw_off) ? ARMED : OFF;
      default: nxt = OFF;
    endcase
  end
  // several checkers may fail in one cycle, so the counter adds a popcount
  always_comb begin
    n_acc = '0;
    for (int i = 0; i < N_CHK; i++) n_acc = n_acc + SW'(acc[i]);
    sum = (sw_clr ? '0 : SW'(fail_cnt)) + n_acc;
  end
  rr_arb #(.N(N_CHK)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .advance  (load),
    .grant    (gnt),
    .grant_vld(gnt_vld)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cur        <= SETTLE;
      settle_cnt <= '0;
      cyc        <= '0;
      chk_en     <= '0;
      pending    <= '0;
      for (int i = 0; i < N_CHK; i++) ts[i] <= '0;
      rpt_valid  <= 1'b0;
      rpt_id     <= '0;
      rpt_time   <= '0;
      fail_cnt   <= '0;
      ovf        <= '0;
    end else begin
      cur <= nxt;
      if (cur == SETTLE) settle_cnt <= settle_cnt + SCW'(1);
      cyc      <= cyc + TS_W'(1);
      chk_en   <= (nxt == ARMED) ? '1 : '0;
      pending  <= acc | (pending & ~clr);
      ovf      <= (sw_clr ? '0 : ovf) | (acc & pending & ~clr);
      fail_cnt <= (sum > SW'({CNT_W{1'b1}})) ? '1 : sum[CNT_W-1:0];
      // a still-pending failure keeps its first timestamp
      for (int i = 0; i < N_CHK; i++)
        if (acc[i] && !(pending[i] && !clr[i])) ts[i] <= cyc;
      if (load) begin
        rpt_valid <= gnt_vld;
        if (gnt_vld) begin
          rpt_id   <= gnt;
          rpt_time <= ts[gnt];
        end
      end
    end
endmodule

// File: tb/tb_chk_ctrl.sv
// tb_chk_ctrl: directed table-driven bench for chk_ctrl with hand-computed expectations
module tb_chk_ctrl;
  logic clk = 1'b0, rst_n = 1'b1, sw_off = 1'b0, sw_on = 1'b0, sw_clr = 1'b0, rpt_ready = 1'b0;
  logic [3:0] chk_fail = 4'h0;
  logic [3:0] chk_en, ovf;
  logic rpt_valid;
  logic [1:0] rpt_id, state;
  logic [15:0] rpt_time;
  logic [7:0] fail_cnt;
  int checks = 0, errors = 0;

  typedef struct {
    logic [2:0]  sw;
    logic [3:0]  fail;
    logic        rdy;
    logic [3:0]  en;
    logic [1:0]  st;
    logic        vld;
    logic [1:0]  id;
    logic [15:0] tm;
    logic [7:0]  cnt;
    logic [3:0]  ovf;
  } vec_t;
  vec_t tbl [30];

  chk_ctrl dut (
    .clk(clk), .rst_n(rst_n), .sw_off(sw_off), .sw_on(sw_on), .sw_clr(sw_clr),
    .chk_fail(chk_fail), .chk_en(chk_en), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
    .rpt_id(rpt_id), .rpt_time(rpt_time), .fail_cnt(fail_cnt), .ovf(ovf), .state(state)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [2:0] sw, input logic [3:0] fail, input logic rdy,
                              input logic [3:0] en, input logic [1:0] st, input logic vld,
                              input logic [1:0] id, input logic [15:0] tm, input logic [7:0] cnt,
                              input logic [3:0] ovf_e);
    vec_t v;
    v.sw = sw; v.fail = fail; v.rdy = rdy; v.en = en; v.st = st;
    v.vld = vld; v.id = id; v.tm = tm; v.cnt = cnt; v.ovf = ovf_e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] sw, input logic [3:0] fail, input logic rdy);
    {sw_off, sw_on, sw_clr} = sw;
    chk_fail = fail;
    rpt_ready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // row j is sampled at edge 41+j, so a failure there captures timestamp 40+j
    tbl[0]  = mk(3'b000, 4'h5, 1'b1, 4'hF, 2'd1, 1'b0, 2'd0, 16'd0,  8'd2, 4'h0);
    tbl[1]  = mk(3'b000, 4'h0, 1'b1, 4'hF, 2'd1, 1'b1, 2'd0, 16'd40, 8'd2, 4'h0);
    tbl[2]  = mk(3'b000, 4'h0, 1'b1, 4'hF, 2'd1, 1'b1, 2'd2, 16'd40, 8'd2, 4'h0);
    tbl[3]  = mk(3'b000, 4'h0, 1'b1, 4'hF, 2'd1, 1'b0, 2'd0, 16'd0,  8'd2, 4'h0);
    tbl[4]  = mk(3'b100, 4'h0, 1'b1, 4'h0, 2'd2, 1'b0, 2'd0, 16'd0,  8'd2, 4'h0);
    tbl[5]  = mk(3'b100, 4'h1, 1'b1, 4'h0, 2'd2, 1'b0, 2'd0, 16'd0,  8'd2, 4'h0);
    tbl[6]  = mk(3'b010, 4'h0, 1'b1, 4'hF, 2'd1, 1'b0, 2'd0, 16'd0,  8'd2, 4'h0);
    tbl[7]  = mk(3'b110, 4'h0, 1'b1, 4'h0, 2'd2, 1'b0, 2'd0, 16'd0,  8'd2, 4'h0);
    tbl[8]  = mk(3'b110, 4'h0, 1'b1, 4'h0, 2'd2, 1'b0, 2'd0, 16'd0,  8'd2, 4'h0);
    tbl[9]  = mk(3'b010, 4'h0, 1'b1, 4'hF, 2'd1, 1'b0, 2'd0, 16'd0,  8'd2, 4'h0);
    tbl[10] = mk(3'b000, 4'h0, 1'b1, 4'hF, 2'd1, 1'b0, 2'd0, 16'd0,  8'd2, 4'h0);
    tbl[11] = mk(3'b000, 4'h2, 1'b0, 4'hF, 2'd1, 1'b0, 2'd0, 16'd0,  8'd3, 4'h0);
    tbl[12] = mk(3'b000, 4'h2, 1'b0, 4'hF, 2'd1, 1'b1, 2'd1, 16'd51, 8'd4, 4'h2);
    tbl[13] = mk(3'b000, 4'h0, 1'b0, 4'hF, 2'd1, 1'b1, 2'd1, 16'd51, 8'd4, 4'h2);
    tbl[14] = mk(3'b000, 4'h2, 1'b0, 4'hF, 2'd1, 1'b1, 2'd1, 16'd51, 8'd5, 4'h2);
    tbl[15] = mk(3'b001, 4'h0, 1'b1, 4'hF, 2'd1, 1'b0, 2'd0, 16'd0,  8'd0, 4'h0);
    tbl[16] = mk(3'b000, 4'h8, 1'b0, 4'hF, 2'd1, 1'b0, 2'd0, 16'd0,  8'd1, 4'h0);
    tbl[17] = mk(3'b000, 4'h0, 1'b0, 4'hF, 2'd1, 1'b1, 2'd3, 16'd56, 8'd1, 4'h0);
    tbl[18] = mk(3'b000, 4'h8, 1'b1, 4'hF, 2'd1, 1'b0, 2'd0, 16'd0,  8'd2, 4'h0);
    tbl[19] = mk(3'b000, 4'h0, 1'b1, 4'hF, 2'd1, 1'b1, 2'd3, 16'd58, 8'd2, 4'h0);
    tbl[20] = mk(3'b000, 4'h0, 1'b1, 4'hF, 2'd1, 1'b0, 2'd0, 16'd0,  8'd2, 4'h0);
    tbl[21] = mk(3'b001, 4'h1, 1'b1, 4'hF, 2'd1, 1'b0, 2'd0, 16'd0,  8'd1, 4'h0);
    tbl[22] = mk(3'b000, 4'h0, 1'b1, 4'hF, 2'd1, 1'b1, 2'd0, 16'd61, 8'd1, 4'h0);
    tbl[23] = mk(3'b000, 4'h0, 1'b1, 4'hF, 2'd1, 1'b0, 2'd0, 16'd0,  8'd1, 4'h0);
    tbl[24] = mk(3'b000, 4'hF, 1'b0, 4'hF, 2'd1, 1'b0, 2'd0, 16'd0,  8'd5, 4'h0);
    tbl[25] = mk(3'b000, 4'h0, 1'b0, 4'hF, 2'd1, 1'b1, 2'd1, 16'd64, 8'd5, 4'h0);
    tbl[26] = mk(3'b000, 4'h0, 1'b1, 4'hF, 2'd1, 1'b1, 2'd2, 16'd64, 8'd5, 4'h0);
    tbl[27] = mk(3'b000, 4'h0, 1'b1, 4'hF, 2'd1, 1'b1, 2'd3, 16'd64, 8'd5, 4'h0);
    tbl[28] = mk(3'b000, 4'h0, 1'b1, 4'hF, 2'd1, 1'b1, 2'd0, 16'd64, 8'd5, 4'h0);
    tbl[29] = mk(3'b000, 4'h0, 1'b1, 4'hF, 2'd1, 1'b0, 2'd0, 16'd0,  8'd5, 4'h0);

    #2 rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_chk_en", 32'(chk_en), 32'h0);
    chk("rst_valid", 32'(rpt_valid), 32'd0);
    chk("rst_id", 32'(rpt_id), 32'd0);
    chk("rst_time", 32'(rpt_time), 32'd0);
    chk("rst_cnt", 32'(fail_cnt), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    drive(3'b000, 4'hF, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("settle%0d_state", i), 32'(state), (i < 15) ? 32'd0 : 32'd1);
      chk($sformatf("settle%0d_en", i), 32'(chk_en), (i < 15) ? 32'h0 : 32'hF);
      chk($sformatf("settle%0d_cnt", i), 32'(fail_cnt), 32'd0);
    end
    drive(3'b000, 4'h0, 1'b1);
    repeat (24) step();
    chk("idle_valid", 32'(rpt_valid), 32'd0);

    for (int i = 0; i < 30; i++) begin
      drive(tbl[i].sw, tbl[i].fail, tbl[i].rdy);
      step();
      chk($sformatf("r%0d_state", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("r%0d_en", i), 32'(chk_en), 32'(tbl[i].en));
      chk($sformatf("r%0d_valid", i), 32'(rpt_valid), 32'(tbl[i].vld));
      chk($sformatf("r%0d_cnt", i), 32'(fail_cnt), 32'(tbl[i].cnt));
      chk($sformatf("r%0d_ovf", i), 32'(ovf), 32'(tbl[i].ovf));
      if (tbl[i].vld) begin
        chk($sformatf("r%0d_id", i), 32'(rpt_id), 32'(tbl[i].id));
        chk($sformatf("r%0d_time", i), 32'(rpt_time), 32'(tbl[i].tm));
      end
    end

    drive(3'b001, 4'h0, 1'b1);
    step();
    chk("sat_clr", 32'(fail_cnt), 32'd0);
    drive(3'b000, 4'h1, 1'b1);
    repeat (254) step();
    chk("sat_254", 32'(fail_cnt), 32'hFE);
    step();
    chk("sat_255", 32'(fail_cnt), 32'hFF);
    drive(3'b000, 4'hF, 1'b1);
    step();
    chk("sat_multi", 32'(fail_cnt), 32'hFF);
    drive(3'b000, 4'h1, 1'b1);
    step();
    chk("sat_one_more", 32'(fail_cnt), 32'hFF);

    drive(3'b000, 4'h4, 1'b0);
    step();
    drive(3'b000, 4'h0, 1'b0);
    step();
    chk("mid_valid", 32'(rpt_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(rpt_valid), 32'd0);
    chk("async_state", 32'(state), 32'd0);
    chk("async_en", 32'(chk_en), 32'h0);
    chk("async_cnt", 32'(fail_cnt), 32'd0);
    chk("async_ovf", 32'(ovf), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'b000, 4'h0, 1'b1);
    step();
    step();
    chk("post_rst_valid", 32'(rpt_valid), 32'd0);
    chk("post_rst_state", 32'(state), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/chk_ctrl.md
CHK_CTRL -- requirements
Module: chk_ctrl

Interface
REQ-001 Parameter N_CHK, default 4, number of checker channels (2..16).
REQ-002 Parameter SETTLE_CYC, default 16, post-reset cycles during which checks stay disabled (>=1).
REQ-003 Parameter CNT_W, default 8, width of failure counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 sw_off  input  1  level; request global check disable.
REQ-007 sw_on  input  1  level; request global check enable.
REQ-008 sw_clr  input  1  pulse; clear fail_cnt and ovf.
REQ-009 chk_fail  input  N_CHK  per-checker failure strobe, one bit per cycle per event.
REQ-010 chk_en  output  N_CHK  per-checker enable, registered.
REQ-011 rpt_valid  output  1  failure report available.
REQ-012 rpt_ready  input  1  consumer accepts report.
REQ-013 rpt_id  output  clog2(N_CHK)  index of reporting checker.
REQ-014 rpt_time  output  16  cycle timestamp of the reported failure.
REQ-015 fail_cnt  output  CNT_W  total accepted failures, saturating.
REQ-016 ovf  output  N_CHK  sticky per-checker dropped-failure flags.
REQ-017 state  output  2  current FSM state encoding.

Function
REQ-018 FSM states SETTLE=0, ARMED=1, OFF=2; encoding 3 unused, SHALL recover to OFF.
REQ-019 SETTLE: settle counter increments each cycle; after SETTLE_CYC cycles in SETTLE -> ARMED; sw_off high -> OFF immediately (priority over counter); sw_on ignored.
REQ-020 ARMED: sw_off high -> OFF next cycle.
REQ-021 OFF: sw_on high and sw_off low -> ARMED next cycle; sw_off and sw_on both high -> stay OFF (off wins).
REQ-022 chk_en = all ones in ARMED, all zeros in SETTLE and OFF.
REQ-023 Free-running 16-bit cycle counter, wraps 0xFFFF -> 0x0000, never stalled.
REQ-024 chk_fail[i] counts only if chk_en[i]=1 in the same cycle; ignored otherwise (no count, no pending, no ovf).
REQ-025 Accepted failure on i: set pending[i], capture cycle counter into ts[i], fail_cnt +1 saturating at all ones.
REQ-026 Accepted failure on i while pending[i] already set and not being reported that cycle: set ovf[i], keep original ts[i], still increment fail_cnt.
REQ-027 Report handshake (rpt_valid & rpt_ready) clears pending of rpt_id; new failure on same i same cycle re-sets pending[i] with new ts, no ovf.
REQ-028 Output stage registered: loaded when rpt_valid=0 or handshake occurs; latency failure-sampled edge E -> rpt_valid high after edge E+1 when stage free.
REQ-029 rpt_id, rpt_time SHALL hold stable while rpt_valid=1 and rpt_ready=0.
REQ-030 Selection round-robin over pending bits not already in output stage; search starts at last granted id +1, modulo N_CHK.
REQ-031 sw_clr zeroes fail_cnt and ovf next cycle; an accepted failure same cycle counts as 1 after clear.
REQ-032 Pending failures drain through rpt regardless of FSM state.

Reset
REQ-033 On rst_n low: state=SETTLE, settle counter=0, cycle counter=0, chk_en=0, pending=0, ts=0, rpt_valid=0, rpt_id=0, rpt_time=0, fail_cnt=0, ovf=0, round-robin pointer so id 0 has highest priority.
REQ-034 Reset asserted mid-report drops rpt_valid asynchronously; queued failures lost.

Structure
REQ-035 Package chk_ctrl_pkg holds state typedef/encoding and timestamp width constant TS_W=16.
REQ-036 Round-robin grant logic in sub-module rr_arb (parameter N, inputs req, advance; outputs grant index, grant valid).

Verification
REQ-037 Reset release, no sw inputs -> chk_en=0 for 16 cycles, then 0xF; state 0->1.
REQ-038 ARMED, chk_fail=0b0101 at cycle counter 40, rpt_ready=1 -> reports id 0 time 40, then id 2 time 40; fail_cnt=2.
REQ-039 sw_off high, chk_fail=0b0001 -> chk_en=0, no report, fail_cnt unchanged; sw_on -> ARMED next cycle.
REQ-040 rpt_ready=0, chk_fail[1] pulsed twice -> one report id 1 with first time, ovf=0b0010, fail_cnt=2; sw_clr -> fail_cnt=0, ovf=0.
REQ-041 Force 255 accepted failures then 1 more -> fail_cnt stays 0xFF.
REQ-042 sw_off and sw_on both high in OFF -> stays OFF; rst_n low while rpt_valid=1 -> rpt_valid=0 immediately.
